// File: rtl/ber_frame_counter.sv
// Bit/frame error accumulator: counts b1_error over NumFrames frames of FRAME_LEN bits
// and offers the totals through a valid/ready result handshake.
module ber_frame_counter #(
    parameter int FRAME_LEN = 48,
    parameter int CW        = 20,
    parameter int FW        = 16
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          nClear,
    input  logic          Start,
    input  logic [FW-1:0] NumFrames,
    input  logic          ErrValid,
    input  logic          b1_error,
    output logic          Busy,
    output logic          FrameErr,
    output logic [CW-1:0] BitErrors,
    output logic [FW-1:0] FrameErrors,
    output logic [FW-1:0] FramesDone,
    output logic          Overflow,
    output logic          ResultValid,
    input  logic          ResultReady
);

    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [IW-1:0] bit_idx_q,   bit_idx_d;
    logic [FW-1:0] target_q,    target_d;
    logic [CW-1:0] bit_err_q,   bit_err_d;
    logic [FW-1:0] frm_err_q,   frm_err_d;
    logic [FW-1:0] frames_q,    frames_d;
    logic          ovf_q,       ovf_d;
    logic          flag_q,      flag_d;
    logic          frame_err_q, frame_err_d;

    // Next-state and counter update logic
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        target_d    = target_q;
        bit_err_d   = bit_err_q;
        frm_err_d   = frm_err_q;
        frames_d    = frames_q;
        ovf_d       = ovf_q;
        flag_d      = flag_q;
        frame_err_d = 1'b0;

        if (!nClear) begin
            state_d   = IDLE;
            bit_idx_d = '0;
            target_d  = '0;
            bit_err_d = '0;
            frm_err_d = '0;
            frames_d  = '0;
            ovf_d     = 1'b0;
            flag_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start && (NumFrames != '0)) begin
                        state_d   = RUN;
                        target_d  = NumFrames;
                        bit_idx_d = '0;
                        bit_err_d = '0;
                        frm_err_d = '0;
                        frames_d  = '0;
                        ovf_d     = 1'b0;
                        flag_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (ErrValid) begin
                        // Saturate rather than wrap; a lost count marks the result as overflowed
                        if (b1_error && (bit_err_q == {CW{1'b1}})) begin
                            ovf_d = 1'b1;
                        end else if (b1_error) begin
                            bit_err_d = bit_err_q + CW'(1);
                        end else begin
                            bit_err_d = bit_err_q;
                        end
                        if (bit_idx_q == LAST_IDX) begin
                            bit_idx_d = '0;
                            frames_d  = frames_q + FW'(1);
                            flag_d    = 1'b0;
                            if (flag_q || b1_error) begin
                                frm_err_d   = frm_err_q + FW'(1);
                                frame_err_d = 1'b1;
                            end else begin
                                frame_err_d = 1'b0;
                            end
                            if ((frames_q + FW'(1)) == target_q) begin
                                state_d = HOLD;
                            end else begin
                                state_d = RUN;
                            end
                        end else begin
                            bit_idx_d = bit_idx_q + IW'(1);
                            flag_d    = flag_q | b1_error;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                HOLD: begin
                    if (ResultReady) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            target_q    <= '0;
            bit_err_q   <= '0;
            frm_err_q   <= '0;
            frames_q    <= '0;
            ovf_q       <= 1'b0;
            flag_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            target_q    <= target_d;
            bit_err_q   <= bit_err_d;
            frm_err_q   <= frm_err_d;
            frames_q    <= frames_d;
            ovf_q       <= ovf_d;
            flag_q      <= flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign Busy        = (state_q == RUN);
    assign ResultValid = (state_q == HOLD);
    assign FrameErr    = frame_err_q;
    assign BitErrors   = bit_err_q;
    assign FrameErrors = frm_err_q;
    assign FramesDone  = frames_q;
    assign Overflow    = ovf_q;

endmodule

// File: doc/ber_frame_counter.md
# ber_frame_counter

Bit- and frame-error accumulator sitting directly downstream of the estimated-bit stage of the decoder. It consumes the per-bit error flag `b1_error` (1 = hard decision disagrees with the ideal bit) and counts over a programmed number of frames of `FRAME_LEN` bits each. It reports the total bit errors, frame errors and frames processed to the measurement controller through a valid/ready result handshake.

## Interface
- `FRAME_LEN`, 48: bits per frame; ≥ 2.
- `CW`, 20: width of the bit-error counter.
- `FW`, 16: width of the frame counters and of `NumFrames`.

- `Clock`  in  1  rising-edge clock, shared with the estimated-bit stage.
- `nReset`  in  1  asynchronous, active-low reset.
- `nClear`  in  1  synchronous active-low clear: next edge forces IDLE, all counters and flags to 0.
- `Start`  in  1  one-cycle pulse that begins a measurement; honoured only in IDLE.
- `NumFrames`  in  FW  frames to measure; sampled on an accepted `Start`.
- `ErrValid`  in  1  `b1_error` holds a fresh sample this cycle. It is driven by the estimated-bit `Enable` delayed one cycle.
- `b1_error`  in  1  error flag of the current bit.
- `Busy`  out  1  state is RUN.
- `FrameErr`  out  1  one-cycle pulse: the frame just completed had ≥ 1 error.
- `BitErrors`  out  CW  bit errors since the last accepted `Start`; saturating.
- `FrameErrors`  out  FW  erroneous frames since the last accepted `Start`.
- `FramesDone`  out  FW  completed frames since the last accepted `Start`.
- `Overflow`  out  1  sticky: `BitErrors` saturated during this measurement.
- `ResultValid`  out  1  final counts are stable and offered.
- `ResultReady`  in  1  consumer accepts the result.

## Operation
- States:
  - IDLE: accepted `Start` with `NumFrames` ≠ 0 → RUN. `Start` with `NumFrames` = 0 is ignored and the state stays IDLE.
  - RUN: counts samples. The edge accepting the last sample of frame `NumFrames` → HOLD.
  - HOLD: `ResultValid`=1. The edge where `ResultValid`&&`ResultReady` → IDLE.
- On an accepted `Start`:
  - `BitErrors`, `FrameErrors`, `FramesDone`, `Overflow`, the bit index and the frame-error flag are zeroed.
  - `NumFrames` is latched into an internal target register.
- In RUN, on each edge with `ErrValid`=1:
  - The bit index increments.
  - If `b1_error`=1: `BitErrors`+1 and the frame-error flag is set.
  - `BitErrors` at all-ones stays all-ones and sets `Overflow`.
- Frame end is the sample with bit index = `FRAME_LEN`-1. On that edge:
  - The index returns to 0 and `FramesDone`+1.
  - If (flag | `b1_error`): `FrameErrors`+1 and `FrameErr` pulses high for the following cycle.
  - The flag clears.
- `ErrValid` is ignored outside RUN and in the cycle `Start` is accepted.
- `Start` is ignored in RUN and HOLD.
- Counters keep their values in HOLD and after returning to IDLE, until the next accepted `Start`.
- `nClear` has priority over all other inputs. `nReset` has priority over `nClear`.
- `FrameErrors` ≤ `FramesDone` ≤ target always; no wrap is possible, since FW bounds the target.

## Timing
- Reset (`nReset`=0 or clear): state IDLE. All of the following are 0: `Busy`, `FrameErr`, `BitErrors`, `FrameErrors`, `FramesDone`, `Overflow`, `ResultValid`.
- All outputs are registered; there are no combinational input→output paths.
- Latency:
  - A sample on edge k is reflected in the counters from cycle k+1.
  - `ResultValid` rises the cycle after the final sample's edge, with final counts already visible.
  - `Busy` falls in that same cycle.
- Handshake:
  - `ResultValid` holds until accepted; `ResultReady` while `ResultValid`=0 has no effect.
  - The earliest new `Start` is the cycle after acceptance, giving 1 cycle of IDLE minimum.
- `ErrValid` may be asserted back-to-back every cycle; the block sustains 1 sample/cycle.
- Reset or clear mid-RUN or mid-HOLD: the measurement is abandoned and no result is offered.

## Test plan
- `FRAME_LEN`=4, `NumFrames`=2, 8 back-to-back samples with errors 0100_0000 → `BitErrors`=1, `FrameErrors`=1, `FramesDone`=2, `FrameErr` pulses once, after sample 4; `ResultValid` rises 1 cycle after sample 8.
- Same setup, errors only on the last bit of frame 2 (bit 8), `ErrValid` gapped every other cycle → `FrameErrors`=1, `BitErrors`=1; gaps do not change the counts.
- `CW`=3, 1 frame of 48 all-error samples → `BitErrors`=7, `Overflow`=1, `FrameErrors`=1.
- Hold `ResultReady`=0 for 10 cycles in HOLD while driving `ErrValid`/`b1_error`=1 and `Start` → counts unchanged, `ResultValid` stays 1; after `ResultReady`=1 → IDLE next cycle.
- `Start` with `NumFrames`=0 → stays IDLE, `Busy`=0. `Start` during RUN → ignored, counts continue.
- `nClear`=0 mid-frame, then `nReset` pulse mid-HOLD → all outputs 0, state IDLE, next `Start` measures from zero.
